// File: rtl/otter_bp_pkg.sv
// ----------------------------------------------------------------------------
// otter_bp_pkg
// Shared types and helpers for the OTTER branch predictor.
//   - bp_entry_t          : one table entry as seen by the lookup path
//                           (valid, tag, counter, target), sized for the
//                           largest supported configuration.
//   - ctr_weak_taken      : counter value with MSB=1, remaining bits 0.
//   - ctr_weak_not_taken  : counter value with MSB=0, remaining bits 1.
//   - bp_index / bp_tag   : table index and tag extraction from a PC.
// ----------------------------------------------------------------------------
package otter_bp_pkg;

    localparam int BP_TAG_W_MAX = 32;
    localparam int BP_CTR_W_MAX = 4;
    localparam int BP_XLEN_MAX  = 64;

    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W_MAX-1:0] tag;
        logic [BP_CTR_W_MAX-1:0] ctr;
        logic [BP_XLEN_MAX-1:0]  target;
    } bp_entry_t;

    function automatic logic [BP_CTR_W_MAX-1:0] ctr_weak_taken(input int ctr_w);
        return BP_CTR_W_MAX'(1 << (ctr_w - 1));
    endfunction

    function automatic logic [BP_CTR_W_MAX-1:0] ctr_weak_not_taken(input int ctr_w);
        return BP_CTR_W_MAX'((1 << (ctr_w - 1)) - 1);
    endfunction

    // Instructions are word aligned, so PC[1:0] never contributes.
    function automatic logic [31:0] bp_index(input logic [BP_XLEN_MAX-1:0] pc,
                                             input int idx_w);
        return 32'((pc >> 2) & ((64'd1 << idx_w) - 64'd1));
    endfunction

    function automatic logic [BP_TAG_W_MAX-1:0] bp_tag(input logic [BP_XLEN_MAX-1:0] pc,
                                                       input int idx_w,
                                                       input int tag_w);
        return BP_TAG_W_MAX'((pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1));
    endfunction

endpackage

// File: rtl/otter_sat_counter.sv
// ----------------------------------------------------------------------------
// otter_sat_counter
// Combinational next-value block for a CTR_W-bit saturating counter.
//   ctr_i  : current counter value
//   inc_i  : 1 = count up (saturate at all-ones), 0 = count down (saturate at 0)
//   ctr_o  : next counter value
// ----------------------------------------------------------------------------
module otter_sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr_i,
    input  logic             inc_i,
    output logic [CTR_W-1:0] ctr_o
);

    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
        end
    end

endmodule

// File: rtl/otter_branch_predictor.sv
// ----------------------------------------------------------------------------
// otter_branch_predictor
// Direct-mapped branch predictor with per-entry tag, target and saturating
// counter. Lookup is combinational from registered state; updates from the
// execute stage are written on the rising clock edge.
//
// Optional feature: define OTTER_BP_GSHARE_EN to add a global history
// register; counters are then indexed by (PC index XOR history) while
// tag/target keep the plain PC index.
//
// Ports:
//   CLK, RST_N       clock, asynchronous active-low reset
//   LK_PC            fetch PC to predict
//   LK_TAKEN/HIT     prediction taken / tag hit
//   LK_TARGET        predicted next PC (stored target or LK_PC+4)
//   UPD_VALID        resolved branch pulse from execute
//   UPD_PC/TAKEN/TARGET  resolved PC, outcome and target
//   UPD_MISPRED      execute flagged a misprediction
//   MISPRED_CNT      saturating count of flagged mispredictions
// ----------------------------------------------------------------------------
module otter_branch_predictor
    import otter_bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int XLEN    = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [XLEN-1:0] LK_PC,
    output logic            LK_TAKEN,
    output logic [XLEN-1:0] LK_TARGET,
    output logic            LK_HIT,
    input  logic            UPD_VALID,
    input  logic [XLEN-1:0] UPD_PC,
    input  logic            UPD_TAKEN,
    input  logic [XLEN-1:0] UPD_TARGET,
    input  logic            UPD_MISPRED,
    output logic [31:0]     MISPRED_CNT
);

    localparam int               IDX_W   = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));

    // Counters live apart from tag/target because gshare indexes them differently.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [CTR_W-1:0]   ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [31:0]        mispred_cnt_q, mispred_cnt_d;

    logic [IDX_W-1:0]        lk_idx, lk_cidx, upd_idx, upd_cidx;
    logic [BP_TAG_W_MAX-1:0] lk_tag, upd_tag;
    bp_entry_t               lk_entry;
    logic [CTR_W-1:0]        lk_ctr, upd_ctr, upd_ctr_next, ctr_wdata;
    logic                    lk_hit, upd_hit, upd_en;
    logic                    ctr_we, tag_we, target_we;

    // Reset gates the update so a pulse caught by reset writes nothing.
    assign upd_en  = UPD_VALID & RST_N;

    assign lk_idx  = IDX_W'(bp_index(BP_XLEN_MAX'(LK_PC), IDX_W));
    assign lk_tag  = bp_tag(BP_XLEN_MAX'(LK_PC), IDX_W, TAG_W);
    assign upd_idx = IDX_W'(bp_index(BP_XLEN_MAX'(UPD_PC), IDX_W));
    assign upd_tag = bp_tag(BP_XLEN_MAX'(UPD_PC), IDX_W, TAG_W);

`ifdef OTTER_BP_GSHARE_EN
    logic [IDX_W-1:0] hist_q, hist_d;

    always_comb begin
        hist_d = hist_q;
        if (upd_en) hist_d = {hist_q[IDX_W-2:0], UPD_TAKEN};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) hist_q <= '0;
        else        hist_q <= hist_d;
    end

    assign lk_cidx  = lk_idx ^ hist_q;
    assign upd_cidx = upd_idx ^ hist_q;
`else
    assign lk_cidx  = lk_idx;
    assign upd_cidx = upd_idx;
`endif

    // Lookup: pure read of registered state, so a same-cycle update is not seen.
    always_comb begin
        lk_entry        = '0;
        lk_entry.valid  = valid_q[lk_idx];
        lk_entry.tag    = BP_TAG_W_MAX'(tag_q[lk_idx]);
        lk_entry.ctr    = BP_CTR_W_MAX'(ctr_q[lk_cidx]);
        lk_entry.target = BP_XLEN_MAX'(target_q[lk_idx]);
    end

    assign lk_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign lk_ctr    = CTR_W'(lk_entry.ctr);
    assign LK_HIT    = lk_hit;
    assign LK_TAKEN  = lk_hit & lk_ctr[CTR_W-1];
    assign LK_TARGET = LK_TAKEN ? XLEN'(lk_entry.target) : LK_PC + XLEN'(4);

    assign upd_hit = valid_q[upd_idx] && (BP_TAG_W_MAX'(tag_q[upd_idx]) == upd_tag);
    assign upd_ctr = ctr_q[upd_cidx];

    otter_sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .ctr_i (upd_ctr),
        .inc_i (UPD_TAKEN),
        .ctr_o (upd_ctr_next)
    );

    always_comb begin
        valid_d   = valid_q;
        ctr_we    = 1'b0;
        ctr_wdata = upd_ctr_next;
        tag_we    = 1'b0;
        target_we = 1'b0;
        if (upd_en) begin
            if (upd_hit) begin
                ctr_we    = 1'b1;
                target_we = UPD_TAKEN;
            end else if (UPD_TAKEN) begin
                // Taken miss allocates (replacing any alias); not-taken miss is dropped.
                valid_d[upd_idx] = 1'b1;
                ctr_we           = 1'b1;
                ctr_wdata        = CTR_WT;
                tag_we           = 1'b1;
                target_we        = 1'b1;
            end
        end
    end

    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && UPD_MISPRED && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + 32'd1;
    end

    assign MISPRED_CNT = mispred_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q       <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_WNT;
        end else begin
            valid_q       <= valid_d;
            mispred_cnt_q <= mispred_cnt_d;
            if (ctr_we) ctr_q[upd_cidx] <= ctr_wdata;
        end
    end

    // NOTE: tag/target storage has no reset; valid gates every read of it.
    always_ff @(posedge CLK) begin
        if (tag_we)    tag_q[upd_idx]    <= TAG_W'(upd_tag);
        if (target_we) target_q[upd_idx] <= UPD_TARGET;
    end

endmodule

// File: tb/tb_otter_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_otter_branch_predictor
// Self-checking bench for otter_branch_predictor (default parameters).
// Directed table of vectors with hand-derived expectations, reset corner
// sequences, and a randomized phase checked against a behavioural model.
// Expected lookup results go through a scoreboard queue.
// ----------------------------------------------------------------------------
module tb_otter_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int TAG_W   = 8;
    localparam int CTR_W   = 2;
    localparam int XLEN    = 32;
    localparam int IDX_W   = 6;
    localparam int CTR_MAX = (1 << CTR_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] lk_pc = '0;
    logic        lk_taken, lk_hit;
    logic [31:0] lk_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispred = 1'b0;
    logic [31:0] mispred_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    otter_branch_predictor #(
        .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CTR_W(CTR_W), .XLEN(XLEN)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .LK_PC       (lk_pc),
        .LK_TAKEN    (lk_taken),
        .LK_TARGET   (lk_target),
        .LK_HIT      (lk_hit),
        .UPD_VALID   (upd_valid),
        .UPD_PC      (upd_pc),
        .UPD_TAKEN   (upd_taken),
        .UPD_TARGET  (upd_target),
        .UPD_MISPRED (upd_mispred),
        .MISPRED_CNT (mispred_cnt)
    );

    typedef struct {
        logic [31:0] lk_pc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic        eh;
        logic        et;
        logic [31:0] etgt;
        logic [31:0] ecnt;
    } vec_t;

    typedef struct {
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    // ---------------- behavioural reference model ----------------
    bit               m_valid [ENTRIES];
    logic [TAG_W-1:0] m_tag   [ENTRIES];
    logic [31:0]      m_tgt   [ENTRIES];
    int               m_ctr   [ENTRIES];
    logic [IDX_W-1:0] m_hist;
    logic [31:0]      m_cnt;

    function automatic int m_pidx(input logic [31:0] pc);
        return int'(pc[IDX_W+1:2]);
    endfunction

    function automatic int m_cidx(input logic [31:0] pc);
`ifdef OTTER_BP_GSHARE_EN
        return int'(pc[IDX_W+1:2] ^ m_hist);
`else
        return int'(pc[IDX_W+1:2]);
`endif
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int i;
        i = m_pidx(pc);
        return m_valid[i] && (m_tag[i] == pc[IDX_W+TAG_W+1:IDX_W+2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = (1 << (CTR_W - 1)) - 1;
        end
        m_hist = '0;
        m_cnt  = '0;
    endtask

    function automatic exp_t model_predict(input logic [31:0] pc);
        exp_t e;
        e.hit   = m_hit(pc);
        e.taken = e.hit && (m_ctr[m_cidx(pc)] >= (1 << (CTR_W - 1)));
        e.tgt   = e.taken ? m_tgt[m_pidx(pc)] : pc + 32'd4;
        e.cnt   = m_cnt;
        return e;
    endfunction

    task automatic model_update(input vec_t v);
        int i, c;
        if (!v.uv) return;
        i = m_pidx(v.upc);
        c = m_cidx(v.upc);
        if (m_hit(v.upc)) begin
            if (v.ut) begin
                if (m_ctr[c] < CTR_MAX) m_ctr[c]++;
                m_tgt[i] = v.utgt;
            end else if (m_ctr[c] > 0) begin
                m_ctr[c]--;
            end
        end else if (v.ut) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = v.upc[IDX_W+TAG_W+1:IDX_W+2];
            m_tgt[i]   = v.utgt;
            m_ctr[c]   = 1 << (CTR_W - 1);
        end
        m_hist = {m_hist[IDX_W-2:0], v.ut};
        if (v.um && m_cnt != 32'hFFFF_FFFF) m_cnt++;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got hit=%0b expected an entry", name, lk_hit);
            return;
        end
        e = sb_q.pop_front();
        check({name, ".hit"},    32'(lk_hit),   32'(e.hit));
        check({name, ".taken"},  32'(lk_taken), 32'(e.taken));
        check({name, ".target"}, lk_target,     e.tgt);
        check({name, ".cnt"},    mispred_cnt,   e.cnt);
    endtask

    function automatic vec_t mk(input logic [31:0] lk, input logic uv, input logic [31:0] upc,
                                input logic ut, input logic [31:0] utgt, input logic um,
                                input logic eh, input logic et, input logic [31:0] etgt,
                                input logic [31:0] ecnt);
        vec_t v;
        v = '{lk, uv, upc, ut, utgt, um, eh, et, etgt, ecnt};
        return v;
    endfunction

    // One cycle: drive after the edge, compare lookup at the falling edge,
    // then advance the model for the update the next rising edge commits.
    task automatic apply(input vec_t v, input exp_t e, input string name);
        @(posedge clk);
        #1;
        lk_pc       = v.lk_pc;
        upd_valid   = v.uv;
        upd_pc      = v.upc;
        upd_taken   = v.ut;
        upd_target  = v.utgt;
        upd_mispred = v.um;
        sb_q.push_back(e);
        @(negedge clk);
        check_out(name);
        model_update(v);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic do_reset();
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        upd_taken   = 1'b0;
        lk_pc       = 32'h100;
        rst_n       = 1'b0;
        #1;
        check("rst.hit",    32'(lk_hit),   32'd0);
        check("rst.taken",  32'(lk_taken), 32'd0);
        check("rst.target", lk_target,     32'h104);
        check("rst.cnt",    mispred_cnt,   32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [18];
        exp_t        e;
        logic [31:0] pool [8];

        //            lk_pc        uv upc          ut utgt     um   hit tk target        cnt
        tbl[0]  = mk(32'h100,      0, 32'h0,       0, 32'h0,   0,   0, 0, 32'h104,      0);
        tbl[1]  = mk(32'h100,      1, 32'h100,     1, 32'h200, 1,   0, 0, 32'h104,      0);
        tbl[2]  = mk(32'h100,      1, 32'h100,     0, 32'h0,   1,   1, 1, 32'h200,      1);
        tbl[3]  = mk(32'h100,      1, 32'h100,     0, 32'h0,   0,   1, 0, 32'h104,      2);
        tbl[4]  = mk(32'h100,      1, 32'h100,     0, 32'h0,   0,   1, 0, 32'h104,      2);
        tbl[5]  = mk(32'h100,      1, 32'h100,     1, 32'h300, 1,   1, 0, 32'h104,      2);
        tbl[6]  = mk(32'h100,      1, 32'h100,     1, 32'h300, 0,   1, 0, 32'h104,      3);
        tbl[7]  = mk(32'h100,      1, 32'h100,     1, 32'h300, 0,   1, 1, 32'h300,      3);
        tbl[8]  = mk(32'h100,      1, 32'h100,     1, 32'h300, 0,   1, 1, 32'h300,      3);
        tbl[9]  = mk(32'h100,      1, 32'h100,     0, 32'h999, 1,   1, 1, 32'h300,      3);
        tbl[10] = mk(32'h100,      0, 32'h0,       0, 32'h0,   1,   1, 1, 32'h300,      4);
        tbl[11] = mk(32'h200,      1, 32'h200,     0, 32'h0,   1,   0, 0, 32'h204,      4);
        tbl[12] = mk(32'h100,      1, 32'h200,     1, 32'h400, 0,   1, 1, 32'h300,      5);
        tbl[13] = mk(32'h100,      0, 32'h0,       0, 32'h0,   0,   0, 0, 32'h104,      5);
        tbl[14] = mk(32'h200,      0, 32'h0,       0, 32'h0,   0,   1, 1, 32'h400,      5);
        tbl[15] = mk(32'hFFFFFFFC, 1, 32'hFFFFFFFC, 1, 32'h10, 0,   0, 0, 32'h0,        5);
        tbl[16] = mk(32'hFFFFFFFC, 0, 32'h0,       0, 32'h0,   0,   1, 1, 32'h10,       5);
        tbl[17] = mk(32'h104,      0, 32'h0,       0, 32'h0,   0,   0, 0, 32'h108,      5);

        pool = '{32'h100, 32'h104, 32'h200, 32'h1100, 32'h13C, 32'hFFFFFFFC, 32'h8, 32'h4100};

        #2;
        do_reset();

        // Directed table: allocate, count down/up with saturation, alias replace, wrap.
        for (int i = 0; i < 18; i++) begin
`ifdef OTTER_BP_GSHARE_EN
            e = model_predict(tbl[i].lk_pc);
`else
            e = '{tbl[i].eh, tbl[i].et, tbl[i].etgt, tbl[i].ecnt};
`endif
            apply(tbl[i], e, $sformatf("tbl%0d", i));
        end
        idle();

        // Reset arriving with an update pending: nothing is written, count clears.
        @(posedge clk);
        #1;
        lk_pc       = 32'h200;
        upd_valid   = 1'b1;
        upd_pc      = 32'h500;
        upd_taken   = 1'b1;
        upd_target  = 32'h600;
        upd_mispred = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.hit",    32'(lk_hit),   32'd0);
        check("midrst.target", lk_target,     32'h204);
        check("midrst.cnt",    mispred_cnt,   32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        upd_valid   = 1'b0;
        upd_mispred = 1'b0;
        rst_n       = 1'b1;
        apply(mk(32'h500, 0, 0, 0, 0, 0, 0, 0, 0, 0), '{1'b0, 1'b0, 32'h504, 32'd0}, "post_rst_500");
        apply(mk(32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0), '{1'b0, 1'b0, 32'h204, 32'd0}, "post_rst_200");
        apply(mk(32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0), '{1'b0, 1'b0, 32'h0, 32'd0}, "post_rst_top");

        // Randomized traffic over a small PC pool, checked against the model.
        for (int n = 0; n < 300; n++) begin
            vec_t v;
            v = mk(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)],
                   1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                   0, 0, 0, 0);
            apply(v, model_predict(v.lk_pc), "rand");
        end
        idle();

`ifdef OTTER_BP_GSHARE_EN
        // History 0b000001 makes PC 0x104 read counter 0 (still weakly-not-taken).
        do_reset();
        apply(mk(32'h104, 1, 32'h104, 1, 32'h500, 0, 0, 0, 0, 0), model_predict(32'h104), "gs_alloc");
        e = model_predict(32'h104);
        apply(mk(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0), e, "gs_model");
        apply(mk(32'h104, 0, 0, 0, 0, 0, 0, 0, 0, 0), '{1'b1, 1'b0, 32'h108, 32'd0}, "gs_hist1");
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
